// File: rtl/conv_enc_k7.sv
// Rate-1/2, K=7 convolutional encoder with optional K-1 zero tail per frame.
// Latency: 1 cycle from input handshake to out_valid; 1 symbol/clk sustained.
// Backpressure: single output register; stalls hold symbol and shift register.
module conv_enc_k7 #(
    parameter int           K       = 7,
    parameter logic [K-1:0] G0      = 7'o171,
    parameter logic [K-1:0] G1      = 7'o133,
    parameter bit           TAIL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_pair,
    output logic       out_last,
    output logic       busy
);

    localparam int SRW = K - 1;
    localparam int TCW = $clog2(K - 1);

    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    state_t           state, state_nxt;
    logic [SRW-1:0]   sr, sr_nxt;
    logic [TCW-1:0]   tail_cnt, tail_nxt;
    logic [1:0]       pair_nxt;
    logic             last_nxt;
    logic             valid_nxt;
    logic             load;
    logic             rdy_int;
    logic             enc;
    logic             u;
    logic [K-1:0]     v;

    // Next-state, encoder datapath and output-register next values.
    always_comb begin
        load      = !out_valid || out_ready;
        rdy_int   = (state == IDLE || state == DATA) && load;
        // Tail slots need no input handshake, only a free output register.
        enc       = (rdy_int && in_valid) || (state == TAIL && load);
        u         = (state == TAIL) ? 1'b0 : in_bit;
        v         = {u, sr};

        state_nxt = state;
        sr_nxt    = sr;
        tail_nxt  = tail_cnt;
        pair_nxt  = out_pair;
        last_nxt  = out_last;
        valid_nxt = out_valid && !out_ready;

        if (enc) begin
            valid_nxt = 1'b1;
            pair_nxt  = {^(v & G1), ^(v & G0)};
            last_nxt  = 1'b0;
            sr_nxt    = {u, sr[SRW-1:1]};
            case (state)
                IDLE, DATA: begin
                    if (!in_last) begin
                        state_nxt = DATA;
                    end else if (TAIL_EN) begin
                        state_nxt = TAIL;
                        tail_nxt  = '0;
                    end else begin
                        // Truncated frame: force the register back to state 0.
                        state_nxt = IDLE;
                        last_nxt  = 1'b1;
                        sr_nxt    = '0;
                    end
                end
                TAIL: begin
                    tail_nxt = tail_cnt + 1'b1;
                    if (tail_cnt == TCW'(K - 2)) begin
                        // K-1 zeros have been shifted in, so sr is back to 0.
                        state_nxt = IDLE;
                        last_nxt  = 1'b1;
                        tail_nxt  = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, shift register and output symbol registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sr        <= '0;
            tail_cnt  <= '0;
            out_valid <= 1'b0;
            out_pair  <= 2'b00;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            sr        <= sr_nxt;
            tail_cnt  <= tail_nxt;
            out_valid <= valid_nxt;
            out_pair  <= pair_nxt;
            out_last  <= last_nxt;
        end
    end

    assign in_ready = rst_n && rdy_int;
    assign busy     = rst_n && (state != IDLE || out_valid);

endmodule

// File: tb/tb_conv_enc_k7.sv
// Self-checking bench for conv_enc_k7 (tailed and truncated instances).
// Inputs driven 1 time unit after posedge; outputs sampled on negedge.
// Drives out_ready high or pseudo-randomly to exercise stalls.
module tb_conv_enc_k7;

    logic       clk;
    logic       rst_n;
    logic [1:0] iv;
    logic       in_bit;
    logic       in_last;
    logic       out_ready;
    logic [1:0] ir, ov, ol, bz;
    logic [1:0] op1, op0;

    int n_chk  = 0;
    int n_fail = 0;
    int ir_low;
    int stall_err;

    logic [1:0] cap_q[$];
    bit         cap_l[$];
    int         cap_c[$];
    logic [1:0] exp_q[$];
    bit         exp_l[$];

    conv_enc_k7 #(.TAIL_EN(1'b1)) dut_tail (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_bit(in_bit), .in_last(in_last),
        .out_valid(ov[1]), .out_ready(out_ready), .out_pair(op1),
        .out_last(ol[1]), .busy(bz[1])
    );

    conv_enc_k7 #(.TAIL_EN(1'b0)) dut_trunc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_bit(in_bit), .in_last(in_last),
        .out_valid(ov[0]), .out_ready(out_ready), .out_pair(op0),
        .out_last(ol[0]), .busy(bz[0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoder written with explicit delay taps (d[1] = newest).
    task automatic model(input int n, input logic [63:0] bits, input bit tail);
        logic [6:1] d;
        logic       u, o0, o1;
        int         tot;
        d   = '0;
        tot = n + (tail ? 6 : 0);
        for (int i = 0; i < tot; i++) begin
            u  = (i < n) ? bits[i] : 1'b0;
            o0 = u ^ d[1] ^ d[2] ^ d[3] ^ d[6];
            o1 = u ^ d[2] ^ d[3] ^ d[5] ^ d[6];
            exp_q.push_back({o1, o0});
            exp_l.push_back(i == tot - 1);
            d = {d[5:1], u};
        end
    endtask

    task automatic cmp_exp(input string tag);
        int m;
        chk({tag, "_cnt"}, cap_q.size(), exp_q.size());
        m = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            chk($sformatf("%s[%0d]", tag, i), {cap_l[i], cap_q[i]}, {exp_l[i], exp_q[i]});
        exp_q.delete();
        exp_l.delete();
    endtask

    // Hand-derived impulse response, first symbol in the top bits.
    task automatic chk_impulse(input string tag);
        logic [13:0] imp;
        imp = {2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};
        chk({tag, "_cnt"}, cap_q.size(), 7);
        for (int i = 0; i < 7 && i < cap_q.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), {cap_l[i], cap_q[i]},
                {(i == 6) ? 1'b1 : 1'b0, imp[13 - 2*i -: 2]});
    endtask

    // Streams n bits into the selected instance and captures symbols
    // until nfr out_last symbols have been transferred.
    task automatic run_stream(input int sel, input int n, input logic [63:0] bits,
                              input logic [63:0] lastm, input int nfr, input bit bp);
        int         idx, cyc, lasts;
        bit         hold;
        logic [1:0] held, p;
        logic       held_l, r, v, l;
        cap_q.delete(); cap_l.delete(); cap_c.delete();
        ir_low = 0; stall_err = 0;
        idx = 0; cyc = 0; lasts = 0; hold = 1'b0; held = '0; held_l = 1'b0;
        while (lasts < nfr && cyc < 400) begin
            iv        = '0;
            iv[sel]   = (idx < n);
            in_bit    = bits[idx];
            in_last   = lastm[idx];
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            r = ir[sel]; v = ov[sel]; l = ol[sel];
            p = (sel == 1) ? op1 : op0;
            if (hold && (!v || p !== held || l !== held_l)) stall_err++;
            hold = v && !out_ready; held = p; held_l = l;
            if (!r) ir_low++;
            if (iv[sel] && r) idx++;
            if (v && out_ready) begin
                cap_q.push_back(p); cap_l.push_back(l); cap_c.push_back(cyc);
                if (l) lasts++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        iv = '0; in_last = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
        chk("frames_done", lasts, nfr);
    endtask

    initial begin
        rst_n = 1'b0; iv = '0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", ir[1], 1'b0);
        chk("rst_busy", bz[1], 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_out_valid", ov[1], 1'b0);
        chk("rel_out_pair", op1, 2'b00);
        chk("rel_out_last", ol[1], 1'b0);
        chk("rel_busy", bz[1], 1'b0);
        chk("rel_in_ready", ir[1], 1'b1);
        @(posedge clk); #1;

        // Impulse with tail
        run_stream(1, 1, 64'h1, 64'h1, 1, 1'b0);
        chk_impulse("impulse");
        @(negedge clk);
        chk("impulse_busy_after", bz[1], 1'b0);
        @(posedge clk); #1;

        // All-zero 10-bit frame: 16 zero symbols, input blocked for the 6 tail cycles
        run_stream(1, 10, 64'h0, 64'h200, 1, 1'b0);
        model(10, 64'h0, 1'b1);
        cmp_exp("zero");
        chk("zero_tail_ready_low", ir_low, 6);

        // Random 32-bit frame under pseudo-random backpressure
        run_stream(1, 32, 64'hB4E1_9C27, 64'h8000_0000, 1, 1'b1);
        model(32, 64'hB4E1_9C27, 1'b1);
        cmp_exp("bp");
        chk("bp_stall_hold", stall_err, 0);

        // Back-to-back single-bit frames with no gap
        run_stream(1, 2, 64'h3, 64'h3, 2, 1'b0);
        model(1, 64'h1, 1'b1);
        model(1, 64'h1, 1'b1);
        cmp_exp("b2b");
        if (cap_c.size() == 14) begin
            chk("b2b_gap", cap_c[7] - cap_c[6], 1);
            chk("b2b_span", cap_c[13] - cap_c[0], 13);
        end else begin
            chk("b2b_size", cap_c.size(), 14);
        end

        // Truncated frames: 1,0,0 then an impulse starting from state 0
        run_stream(0, 3, 64'h1, 64'h4, 1, 1'b0);
        model(3, 64'h1, 1'b0);
        cmp_exp("trunc");
        run_stream(0, 1, 64'h1, 64'h1, 1, 1'b0);
        model(1, 64'h1, 1'b0);
        cmp_exp("trunc_next");

        // Reset during tail, then a clean impulse
        iv[1] = 1'b1; in_bit = 1'b1; in_last = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        iv = '0; in_bit = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_busy_before", bz[1], 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", bz[1], 1'b0);
        chk("mid_rst_in_ready", ir[1], 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_out_valid", ov[1], 1'b0);
        chk("mid_busy", bz[1], 1'b0);
        @(posedge clk); #1;
        run_stream(1, 1, 64'h1, 64'h1, 1, 1'b0);
        chk_impulse("post_rst");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
